// File: rtl/mem_bus_pkg.sv
// Shared definitions for the memory bus master and memory_controller.
// Holds bus widths, the memory map region bases and the bus FSM state type.
package mem_bus_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;

  // Memory map: ROM [0x00..0x1F], IO [0x20..0x3F], RAM [0x40..0x5F]
  localparam logic [ADDR_W-1:0] ROM_BASE = 16'h0000;
  localparam logic [ADDR_W-1:0] IO_BASE  = 16'h0020;
  localparam logic [ADDR_W-1:0] RAM_BASE = 16'h0040;
  localparam logic [ADDR_W-1:0] MEM_TOP  = 16'h0060;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } bus_state_e;

endpackage

// File: rtl/mem_bus_master.sv
// mem_bus_master: turns one CPU-side request into a single-word bus cycle
// on the memory_controller port, then returns the result on a valid/ready
// response port. One transaction outstanding at a time.
//
// Ports:
//   clock, reset              rising-edge clock, synchronous active-high reset
//   req_valid/req_ready       request handshake; req_we, req_addr, req_wdata
//   rsp_valid/rsp_ready       response handshake; rsp_rdata, rsp_err
//   mem_address/mem_wdata/mem_we  drive memory_controller
//   mem_rdata                 read data from memory_controller
//
// Optional build macro MEM_RANGE_CHECK_EN: requests with req_addr >=
// ADDR_LIMIT bypass the bus cycle and answer with rsp_err = 1. Without it
// rsp_err is tied 0 and every address runs a normal bus cycle.
module mem_bus_master
  import mem_bus_pkg::*;
#(
  parameter int                READ_WAIT  = 1,       // 1..15 ACCESS cycles for reads
  parameter logic [ADDR_W-1:0] ADDR_LIMIT = 16'h0060 // first unmapped address
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [3:0] WAIT_INIT = 4'(READ_WAIT - 1);

  bus_state_e state, state_n;
  logic       we_q;
  logic [3:0] wait_cnt;
  logic       addr_bad;

`ifdef MEM_RANGE_CHECK_EN
  assign addr_bad = (req_addr >= ADDR_LIMIT);

  // Error flag lives for exactly one response.
  always_ff @(posedge clock) begin
    if (reset)                          rsp_err <= 1'b0;
    else if (state == IDLE && req_valid) rsp_err <= addr_bad;
    else if (state == RESP && rsp_ready) rsp_err <= 1'b0;
  end
`else
  logic unused_limit;
  assign unused_limit = ^ADDR_LIMIT;
  assign addr_bad     = 1'b0;
  assign rsp_err      = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:   if (req_valid) state_n = addr_bad ? RESP : SETUP;
      SETUP:  state_n = ACCESS;
      ACCESS: if (we_q || wait_cnt == 4'd0) state_n = RESP;
      RESP:   if (rsp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Strobes decode straight from registered state, so mem_we cannot glitch
  // and drops on the edge that applies reset.
  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign mem_we    = (state == ACCESS) && we_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      mem_address <= '0;
      mem_wdata   <= '0;
      we_q        <= 1'b0;
      wait_cnt    <= 4'd0;
      rsp_rdata   <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          // Writes and errors answer with zero data; reads overwrite later.
          rsp_rdata <= '0;
          // Out-of-range requests leave the bus untouched.
          if (!addr_bad) begin
            mem_address <= req_addr;
            mem_wdata   <= req_wdata;
            we_q        <= req_we;
          end
        end
        SETUP: wait_cnt <= WAIT_INIT;
        ACCESS: if (!we_q) begin
          if (wait_cnt == 4'd0) rsp_rdata <= mem_rdata;
          else                  wait_cnt  <= wait_cnt - 4'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_master.sv
module tb_mem_bus_master;
  import mem_bus_pkg::*;

  typedef struct {
    logic [31:0] rd;
    logic [31:0] rd_alt;
    logic        err;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  // Shared stimulus; sel steers it to DUT a (READ_WAIT=1) or b (READ_WAIT=4)
  logic        sel = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b0;
  logic [15:0] req_addr = '0;
  logic [31:0] req_wdata = '0;

  logic        a_req_valid, a_req_ready, a_rsp_valid, a_rsp_ready, a_rsp_err, a_mem_we;
  logic [31:0] a_rsp_rdata, a_mem_wdata, a_mem_rdata;
  logic [15:0] a_mem_address;
  logic        b_req_valid, b_req_ready, b_rsp_valid, b_rsp_ready, b_rsp_err, b_mem_we;
  logic [31:0] b_rsp_rdata, b_mem_wdata, b_mem_rdata;
  logic [15:0] b_mem_address;

  assign a_req_valid = req_valid & ~sel;
  assign b_req_valid = req_valid & sel;
  assign a_rsp_ready = rsp_ready & ~sel;
  assign b_rsp_ready = rsp_ready & sel;

  logic        rq_ready, rs_valid, rs_err, m_we;
  logic [31:0] rs_rdata;
  logic [15:0] m_addr;
  assign rq_ready = sel ? b_req_ready : a_req_ready;
  assign rs_valid = sel ? b_rsp_valid : a_rsp_valid;
  assign rs_err   = sel ? b_rsp_err   : a_rsp_err;
  assign rs_rdata = sel ? b_rsp_rdata : a_rsp_rdata;
  assign m_we     = sel ? b_mem_we    : a_mem_we;
  assign m_addr   = sel ? b_mem_address : a_mem_address;

  mem_bus_master #(.READ_WAIT(1)) u_dut_a (
    .clock(clock), .reset(reset),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_rdata(a_rsp_rdata),
    .rsp_err(a_rsp_err), .mem_address(a_mem_address), .mem_wdata(a_mem_wdata),
    .mem_we(a_mem_we), .mem_rdata(a_mem_rdata)
  );

  mem_bus_master #(.READ_WAIT(4)) u_dut_b (
    .clock(clock), .reset(reset),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata),
    .rsp_err(b_rsp_err), .mem_address(b_mem_address), .mem_wdata(b_mem_wdata),
    .mem_we(b_mem_we), .mem_rdata(b_mem_rdata)
  );

  // Memory controller stand-in: ROM word = C0DE0000|addr, IO reads 0,
  // RAM writable by DUT a, unmapped reads 0.
  logic [31:0] ram [0:31];
  logic        ram_init = 1'b0;
  always @(posedge clock) begin
    if (!ram_init) begin
      for (int i = 0; i < 32; i++) ram[i] <= '0;
      ram_init <= 1'b1;
    end else if (a_mem_we && a_mem_address >= RAM_BASE && a_mem_address < MEM_TOP)
      ram[a_mem_address[4:0]] <= a_mem_wdata;
  end

  always_comb begin
    a_mem_rdata = '0;
    if (a_mem_address < IO_BASE) a_mem_rdata = 32'hC0DE_0000 | 32'(a_mem_address);
    else if (a_mem_address >= RAM_BASE && a_mem_address < MEM_TOP) a_mem_rdata = ram[a_mem_address[4:0]];
  end
  always_comb begin
    b_mem_rdata = '0;
    if (b_mem_address < IO_BASE) b_mem_rdata = 32'hC0DE_0000 | 32'(b_mem_address);
    else if (b_mem_address >= RAM_BASE && b_mem_address < MEM_TOP) b_mem_rdata = ram[b_mem_address[4:0]];
  end

  int b_we_total = 0;
  always @(negedge clock) if (b_mem_we !== 1'b0 && !reset) b_we_total++;

  int   n_asrt = 0, n_fail = 0;
  exp_t sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // Pop the oldest expected response and compare it to the DUT output.
  task automatic sb_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      n_asrt++; n_fail++;
      $error("FAIL %s: observed response, expected none queued", tag);
    end else begin
      e = sb.pop_front();
      n_asrt++;
      assert (rs_rdata === e.rd || rs_rdata === e.rd_alt) else begin
        n_fail++;
        $error("FAIL %s rdata: observed %h, expected %h or %h", tag, rs_rdata, e.rd, e.rd_alt);
      end
      chk({tag, " err"}, 32'(rs_err), 32'(e.err));
    end
  endtask

  task automatic push(input logic [31:0] rd, input logic [31:0] alt, input logic err);
    exp_t e;
    e.rd = rd; e.rd_alt = alt; e.err = err;
    sb.push_back(e);
  endtask

  // One full transaction. elat: negedges after the accepting edge until
  // rsp_valid; ewe_at: cycle of the mem_we pulse (0 = none expected).
  task automatic do_req(input string tag, input logic s, input logic we,
                        input logic [15:0] addr, input logic [31:0] wd,
                        input logic [31:0] erd, input logic [31:0] ealt, input logic eerr,
                        input int elat, input int ewe_at, input int stall);
    int g, cyc, we_at, we_n;
    @(negedge clock);
    sel = s; req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd;
    push(erd, ealt, eerr);
    g = 0;
    while (!rq_ready && g < 40) begin @(negedge clock); g++; end
    @(posedge clock);
    cyc = 0; we_at = 0; we_n = 0;
    do begin
      @(negedge clock);
      req_valid = 1'b0;
      cyc++;
      if (m_we === 1'b1) begin we_n++; if (we_at == 0) we_at = cyc; end
    end while (rs_valid !== 1'b1 && cyc < 60);
    chk({tag, " latency"}, 32'(cyc), 32'(elat));
    chk({tag, " we_at"}, 32'(we_at), 32'(ewe_at));
    chk({tag, " we_pulses"}, 32'(we_n), (ewe_at != 0) ? 32'd1 : 32'd0);
    for (int i = 0; i < stall; i++) begin
      chk({tag, " stall valid"}, 32'(rs_valid), 32'd1);
      chk({tag, " stall req_ready"}, 32'(rq_ready), 32'd0);
      chk({tag, " stall rdata"}, rs_rdata, erd);
      @(negedge clock);
    end
    rsp_ready = 1'b1;
    sb_check(tag);
    @(negedge clock);
    rsp_ready = 1'b0;
    chk({tag, " post valid"}, 32'(rs_valid), 32'd0);
    chk({tag, " post req_ready"}, 32'(rq_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g, cyc;
    // Reset state of both instances
    repeat (2) @(negedge clock);
    chk("rst a req_ready", 32'(a_req_ready), 32'd1);
    chk("rst a rsp_valid", 32'(a_rsp_valid), 32'd0);
    chk("rst a rsp_rdata", a_rsp_rdata, 32'd0);
    chk("rst a rsp_err",   32'(a_rsp_err), 32'd0);
    chk("rst a mem_addr",  32'(a_mem_address), 32'd0);
    chk("rst a mem_wdata", a_mem_wdata, 32'd0);
    chk("rst a mem_we",    32'(a_mem_we), 32'd0);
    chk("rst b req_ready", 32'(b_req_ready), 32'd1);
    chk("rst b rsp_valid", 32'(b_rsp_valid), 32'd0);
    reset = 1'b0;

    // Write then read back through RAM, READ_WAIT = 1
    do_req("wr45", 0, 1, 16'h0045, 32'hDEADBEEF, 32'h0, 32'h0, 0, 3, 2, 0);
    do_req("rd45", 0, 0, 16'h0045, 32'h0, 32'hDEADBEEF, 32'hDEADBEEF, 0, 3, 0, 0);
    // Other regions and the last mapped word
    do_req("rd_rom1f", 0, 0, 16'h001F, 32'h0, 32'hC0DE001F, 32'hC0DE001F, 0, 3, 0, 0);
    do_req("rd_io21",  0, 0, 16'h0021, 32'h0, 32'h0, 32'h0, 0, 3, 0, 0);
    do_req("wr5f", 0, 1, 16'h005F, 32'h0F0F0F0F, 32'h0, 32'h0, 0, 3, 2, 0);
    do_req("rd5f", 0, 0, 16'h005F, 32'h0, 32'h0F0F0F0F, 32'h0F0F0F0F, 0, 3, 0, 0);

    // READ_WAIT = 4 instance reading ROM
    do_req("rw4 rd03", 1, 0, 16'h0003, 32'h0, 32'hC0DE0003, 32'hC0DE0003, 0, 6, 0, 0);

    // Response backpressure
    do_req("bp rd45", 0, 0, 16'h0045, 32'h0, 32'hDEADBEEF, 32'hDEADBEEF, 0, 3, 0, 5);

    // Out-of-range access
`ifdef MEM_RANGE_CHECK_EN
    do_req("rng wr100", 0, 1, 16'h0100, 32'h0BAD0BAD, 32'h0, 32'h0, 1, 1, 0, 0);
    chk("rng addr held", 32'(a_mem_address), 32'h0045);
    do_req("rng rd100", 0, 0, 16'h0100, 32'h0, 32'h0, 32'h0, 1, 1, 0, 0);
`else
    do_req("rng wr100", 0, 1, 16'h0100, 32'h0BAD0BAD, 32'h0, 32'h0, 0, 3, 2, 0);
    do_req("rng rd100", 0, 0, 16'h0100, 32'h0, 32'h0, 32'h0, 0, 3, 0, 0);
`endif

    // Back-to-back with req_valid held across the first response
    @(negedge clock);
    sel = 1'b0; req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h0050; req_wdata = 32'hA5A55A5A;
    push(32'h0, 32'h0, 1'b0);
    g = 0;
    while (!rq_ready && g < 40) begin @(negedge clock); g++; end
    @(posedge clock);
    cyc = 0;
    do begin @(negedge clock); cyc++; end while (rs_valid !== 1'b1 && cyc < 60);
    chk("b2b wr latency", 32'(cyc), 32'd3);
    chk("b2b busy req_ready", 32'(rq_ready), 32'd0);
    rsp_ready = 1'b1;
    sb_check("b2b wr");
    req_we = 1'b0; req_addr = 16'h0045; req_wdata = 32'h11112222;
    @(negedge clock);
    rsp_ready = 1'b0;
    chk("b2b idle req_ready", 32'(rq_ready), 32'd1);
    chk("b2b idle rsp_valid", 32'(rs_valid), 32'd0);
    push(32'hDEADBEEF, 32'hDEADBEEF, 1'b0);
    @(negedge clock);
    req_valid = 1'b0;
    chk("b2b second accepted", 32'(rq_ready), 32'd0);
    chk("b2b second addr", 32'(m_addr), 32'h0045);
    chk("b2b second wdata", a_mem_wdata, 32'h11112222);
    cyc = 1;
    do begin @(negedge clock); cyc++; end while (rs_valid !== 1'b1 && cyc < 60);
    chk("b2b rd latency", 32'(cyc), 32'd3);
    rsp_ready = 1'b1;
    sb_check("b2b rd");
    @(negedge clock);
    rsp_ready = 1'b0;
    do_req("rd50", 0, 0, 16'h0050, 32'h0, 32'hA5A55A5A, 32'hA5A55A5A, 0, 3, 0, 0);

    // Reset during the write ACCESS cycle
    @(negedge clock);
    sel = 1'b0; req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h0046; req_wdata = 32'h12345678;
    g = 0;
    while (!rq_ready && g < 40) begin @(negedge clock); g++; end
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    @(negedge clock);
    chk("rst_access mem_we", 32'(a_mem_we), 32'd1);
    reset = 1'b1;
    @(negedge clock);
    chk("rst_access after mem_we", 32'(a_mem_we), 32'd0);
    chk("rst_access after req_ready", 32'(a_req_ready), 32'd1);
    chk("rst_access after rsp_valid", 32'(a_rsp_valid), 32'd0);
    reset = 1'b0;
    do_req("rd46", 0, 0, 16'h0046, 32'h0, 32'h0, 32'h12345678, 0, 3, 0, 0);

    chk("rw4 never wrote", 32'(b_we_total), 32'd0);
    chk("scoreboard drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
